// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//
// Front-end for a 4-bit combinational ALU. Operand A, operand B and a 3-bit
// opcode arrive one nibble per load strobe on din and are held stable on the
// ALU input pins. One cycle after the opcode is captured, the ALU result and
// flags are registered. Completion is reported with a sticky valid and a
// one-cycle done pulse. An illegal opcode raises err, and completed
// operations are counted.
//
// Parameters:
//   N_OPS  number of legal opcodes; sel values >= N_OPS are flagged illegal
//   CNT_W  width of the completed-operation counter (wraps)
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst         in   synchronous active-high reset (beats clr and load)
//   din[3:0]    in   nibble bus: operand, or opcode in din[2:0]
//   load        in   strobe consuming din in the capture states
//   clr         in   synchronous abort back to S_A (beats load)
//   alu_a[3:0]  out  registered operand A to the ALU
//   alu_b[3:0]  out  registered operand B to the ALU
//   alu_sel[2:0] out registered opcode to the ALU
//   alu_result[7:0], alu_carry, alu_zero  in  combinational ALU outputs
//   result[7:0], carry, zero  out  registered ALU outputs
//   err         out  last completed operation used an illegal opcode
//   valid       out  sticky: result/flags are valid
//   done        out  one-cycle pulse when a result is registered
//   busy        out  high in S_B, S_OP and S_EXEC
//   op_count    out  completed-operation counter
// ---------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int N_OPS = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             load,
    input  logic             clr,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic [7:0]       result,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_DONE
    } state_t;

    // Widened copy of N_OPS so the illegal-opcode compare has matching widths.
    localparam logic [31:0] N_OPS_W = 32'(N_OPS);

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state and datapath update. Everything holds by default; done is
    // the only output that falls back to zero so that it pulses for a single
    // cycle. clr wins over load, and an abort in S_EXEC skips the result
    // update entirely because the S_EXEC branch is never reached.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        count_d  = count_q;

        if (clr) begin
            state_d = S_A;
        end else begin
            case (state_q)
                // S_DONE behaves like S_A on load: a new operation starts and
                // the previous result is no longer reported as valid.
                S_A, S_DONE: begin
                    if (load) begin
                        a_d     = din;
                        valid_d = 1'b0;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (load) begin
                        b_d     = din;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (load) begin
                        sel_d   = din[2:0];
                        state_d = S_EXEC;
                    end
                end
                // The ALU is combinational on the held operands, so its
                // outputs are already settled during this single cycle.
                S_EXEC: begin
                    result_d = alu_result;
                    carry_d  = alu_carry;
                    zero_d   = alu_zero;
                    err_d    = ({29'd0, sel_q} >= N_OPS_W);
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    state_d  = S_DONE;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset; reset clears
    // every output and discards any partially collected operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sel  = sel_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign err      = err_q;
    assign valid    = valid_q;
    assign done     = done_q;
    assign op_count = count_q;
    assign busy     = (state_q == S_B) || (state_q == S_OP) || (state_q == S_EXEC);

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream front-end for the 4-bit ALU. It collects operand A, operand B and the 3-bit opcode one nibble at a time from the narrow input pins, then holds them stable on the ALU inputs. One cycle later it registers the ALU result and flags, and reports completion with a sticky valid and a one-cycle done pulse. It also flags illegal opcodes and counts completed operations.

Parameters:
N_OPS, 6, number of legal opcodes; sel values >= N_OPS are illegal.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
din  input  4  nibble bus: operand or opcode (opcode in din[2:0], din[3] ignored)
load  input  1  strobe; each cycle high consumes din in capture states
clr  input  1  synchronous abort; returns FSM to S_A, keeps result/count
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_sel  output  3  registered opcode to ALU
alu_result  input  8  ALU result (combinational from alu_a/b/sel)
alu_carry  input  1  ALU carry/borrow
alu_zero  input  1  ALU zero flag
result  output  8  registered result
carry  output  1  registered carry
zero  output  1  registered zero
err  output  1  registered illegal-opcode flag for last operation
valid  output  1  result/flags valid (sticky)
done  output  1  one-cycle pulse when result registered
busy  output  1  high in S_B, S_OP, S_EXEC
op_count  output  CNT_W  completed operations, wraps

Behaviour:
- Reset (rst=1 at clock edge): all outputs 0, FSM in S_A. Reset mid-operation discards partial operands.
- Reset does not take effect asynchronously.
- States:
  - S_A: on load, alu_a<=din, valid<=0, go to S_B.
  - S_B: on load, alu_b<=din, go to S_OP.
  - S_OP: on load, alu_sel<=din[2:0], go to S_EXEC.
  - S_EXEC: unconditional, one cycle. At its closing edge:
    - result<=alu_result, carry<=alu_carry, zero<=alu_zero.
    - err<=(alu_sel>=N_OPS).
    - valid<=1, done<=1 for one cycle, op_count<=op_count+1 (wraps 2^CNT_W-1 -> 0).
    - Go to S_DONE.
  - S_DONE: hold everything. On load, act as S_A: alu_a<=din, valid<=0, go to S_B.
- Without load, S_A/S_B/S_OP hold. load is ignored in S_EXEC.
- Latency: opcode load at edge t, S_EXEC during cycle t..t+1, result/valid/done visible after edge t+1.
- Operands stay stable on alu_a/b/sel from capture until the next load overwrites them. The ALU is purely combinational, so alu_result is settled within S_EXEC.
- Illegal opcode: err=1. The result is whatever the ALU returns (0 for undefined sel), and zero follows the ALU.
- clr:
  - Any state goes to S_A next edge.
  - clr beats load in the same cycle; that din is not captured.
  - clr during S_EXEC aborts: no result update, no done, no count.
  - valid, result, err and op_count are unchanged by clr. alu_a/b/sel keep their values.
- rst beats clr and load.
- busy = state in {S_B, S_OP, S_EXEC}. It is 0 in S_A and S_DONE.

Test Plan:
1. rst; load din=3, 5, 0 on consecutive cycles -> alu_a=3, alu_b=5, alu_sel=0. One cycle after the third load: result=0x08, carry=0, zero=0, err=0, done pulse, valid=1, op_count=1.
2. A=2, B=5, sel=1 -> result=0xFD, carry=1, zero=0. A=15, B=15, sel=5 -> result=0xE1, op_count=3.
3. A=6, B=9, sel=2 (AND) -> result=0x00, zero=1. Then sel=6 sequence -> err=1, result=0, zero=1, valid=1.
4. Load A=4, B=4, then assert clr together with the opcode load -> state S_A, no done, op_count unchanged, valid stays at its prior value. Next full sequence completes normally.
5. Gaps: load low for 3 cycles between nibbles -> same result as back-to-back. Load held high in S_EXEC -> ignored. Next load in S_DONE clears valid and captures A.
6. rst asserted while in S_OP -> all outputs 0 next edge. Preload op_count to 255 via 255 operations (CNT_W=8) -> the 256th wraps to 0.
